// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop resync, falling-edge start detect, mid-bit sampling, one-cycle rx_flag.
// Optional stop-bit check with rx_frame_err output when UART_RX_FRAME_ERR_EN is defined.
module uart_rx #(
  parameter int CLK_DIV  = 5208,
  parameter int HALF_DIV = CLK_DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
`ifdef UART_RX_FRAME_ERR_EN
  output logic       rx_frame_err,
`endif
  output logic       rx_flag
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] HALF = BW'(HALF_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          flag_q, flag_d;
  logic          sync1_q, sync2_q, dly_q;
  logic [1:0]    settle_q, settle_d;
  logic          arm_q, arm_d;
  logic          fall;
`ifdef UART_RX_FRAME_ERR_EN
  logic          err_q, err_d;
`endif

  // Synchroniser presets read as idle; the edge detector stays disarmed until a
  // genuinely synchronised high has been seen, so a line held low across reset is not a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      dly_q    <= 1'b1;
      settle_q <= '0;
      arm_q    <= 1'b0;
    end else begin
      sync1_q  <= rs232_rx;
      sync2_q  <= sync1_q;
      dly_q    <= sync2_q;
      settle_q <= settle_d;
      arm_q    <= arm_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
`ifdef UART_RX_FRAME_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    settle_d = {settle_q[0], 1'b1};
    arm_d    = arm_q | (settle_q[1] & sync2_q);
    fall     = arm_q & ~sync2_q & dly_q;
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    flag_d   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (baud_q == HALF) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == LAST) begin
          baud_d          = '0;
          shreg_d[bit_q]  = sync2_q;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == LAST) begin
          baud_d  = '0;
          state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          if (sync2_q) begin
            flag_d = 1'b1;
            data_d = shreg_q;
          end else begin
            err_d  = 1'b1;
          end
`else
          flag_d = 1'b1;
          data_d = shreg_q;
`endif
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data = data_q;
  assign rx_flag = flag_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign rx_frame_err = err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model predicts flag cycle and byte from each driven frame.
module tb_uart_rx;
  localparam int CD  = 16;
  localparam int LAT = 3 + CD / 2 + 9 * CD + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rs232_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_flag;
`ifdef UART_RX_FRAME_ERR_EN
  logic       rx_frame_err;
  int         err_cyc[$];
`endif

  always #5 clk = ~clk;

  uart_rx #(.CLK_DIV(CD)) dut (
    .clk(clk),
    .rst(rst),
    .rs232_rx(rs232_rx),
    .rx_data(rx_data),
`ifdef UART_RX_FRAME_ERR_EN
    .rx_frame_err(rx_frame_err),
`endif
    .rx_flag(rx_flag)
  );

  typedef struct {int at; logic [7:0] d; bit err;} exp_t;
  exp_t       q[$];
  logic [7:0] model_data = 8'h00;
  int         cyc = 0;
  int         flag_cyc[$];
  logic [7:0] flag_dat[$];
  int         t0s[$];
  int         checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle compare against the frame model.
  always @(negedge clk) begin
    logic ef;
`ifdef UART_RX_FRAME_ERR_EN
    logic ee;
    ee = 1'b0;
`endif
    ef = 1'b0;
    if (rst) begin
      chk("rst_flag", {31'd0, rx_flag}, 32'd0);
      chk("rst_data", {24'd0, rx_data}, 32'd0);
    end else begin
      if (q.size() > 0 && q[0].at == cyc) begin
        if (q[0].err) begin
`ifdef UART_RX_FRAME_ERR_EN
          ee = 1'b1;
`endif
        end else begin
          ef = 1'b1;
          model_data = q[0].d;
        end
        void'(q.pop_front());
      end
      chk("rx_flag", {31'd0, rx_flag}, {31'd0, ef});
      chk("rx_data", {24'd0, rx_data}, {24'd0, model_data});
`ifdef UART_RX_FRAME_ERR_EN
      chk("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, ee});
      if (rx_frame_err) err_cyc.push_back(cyc);
`endif
      if (rx_flag) begin
        flag_cyc.push_back(cyc);
        flag_dat.push_back(rx_data);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame starting now (just after an edge) and records the expectation.
  task automatic send(input logic [7:0] b, input logic stop);
    exp_t e;
    e.at  = cyc + LAT;
    e.d   = b;
`ifdef UART_RX_FRAME_ERR_EN
    e.err = !stop;
`else
    e.err = 1'b0;
`endif
    q.push_back(e);
    t0s.push_back(cyc);
    rs232_rx = 1'b0;
    wait_cycles(CD);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      wait_cycles(CD);
    end
    rs232_rx = stop;
    wait_cycles(CD);
  endtask

  initial begin
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(20);

    // Single frame 0x55 and its latency
    send(8'h55, 1'b1);
    wait_cycles(20);
    chk("lat_model", LAT, 156);
    chk("flags_after_55", flag_cyc.size(), 1);
    if (flag_cyc.size() >= 1) begin
      chk("lat_55", flag_cyc[0] - t0s[0], 156);
      chk("data_55", {24'd0, flag_dat[0]}, 32'h55);
    end

    // Short low glitch is a false start
    rs232_rx = 1'b0;
    wait_cycles(4);
    rs232_rx = 1'b1;
    wait_cycles(40);
    chk("glitch_noflag", flag_cyc.size(), 1);

    // Back-to-back frames with no idle gap
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    wait_cycles(20);
    chk("flags_after_b2b", flag_cyc.size(), 3);
    if (flag_cyc.size() >= 3) begin
      chk("b2b_spacing", flag_cyc[2] - flag_cyc[1], 160);
      chk("b2b_data0", {24'd0, flag_dat[1]}, 32'hA5);
      chk("b2b_data1", {24'd0, flag_dat[2]}, 32'h3C);
    end

    // Reset in the middle of data bit 4, line kept low across release
    rs232_rx = 1'b0;
    wait_cycles(CD * 5 + CD / 2);
    rst = 1'b1;
    q.delete();
    model_data = 8'h00;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(40);
    rs232_rx = 1'b1;
    wait_cycles(40);
    chk("abort_noflag", flag_cyc.size(), 3);
    send(8'h81, 1'b1);
    wait_cycles(20);
    chk("flags_after_81", flag_cyc.size(), 4);
    if (flag_cyc.size() >= 4) chk("data_81", {24'd0, flag_dat[3]}, 32'h81);

    // Bad stop bit
    send(8'hF0, 1'b0);
    rs232_rx = 1'b1;
    wait_cycles(20);
`ifdef UART_RX_FRAME_ERR_EN
    chk("ferr_noflag", flag_cyc.size(), 4);
    chk("ferr_pulses", err_cyc.size(), 1);
    chk("ferr_data_kept", {24'd0, rx_data}, 32'h81);
`else
    chk("badstop_flags", flag_cyc.size(), 5);
    if (flag_cyc.size() >= 5) chk("badstop_data", {24'd0, flag_dat[4]}, 32'hF0);
`endif

    // Transmitter-style loopback frame 0x55
    send(8'h55, 1'b1);
    wait_cycles(20);
    if (flag_cyc.size() > 0) chk("loop_data", {24'd0, flag_dat[flag_cyc.size()-1]}, 32'h55);
`ifdef UART_RX_FRAME_ERR_EN
    chk("loop_flags", flag_cyc.size(), 5);
`else
    chk("loop_flags", flag_cyc.size(), 6);
`endif

    chk("model_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
